// File: rtl/eth_rx_dst_filter.sv
// Receive destination-MAC filter: holds the 6-byte destination, then forwards or discards the frame.
// Optional multicast acceptance is enabled by defining ETH_RX_DST_FILTER_MCAST_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | between frames, waiting for the first byte
// S_HDR    | collecting destination bytes 2..6
// S_PASS   | frame accepted, streaming with a 6-byte delay
// S_DROP   | frame rejected, discarding until tlast
// S_DRAIN  | input frame ended, emitting the 6 buffered bytes
module eth_rx_dst_filter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    input  logic [47:0]          local_mac,
    input  logic                 promisc,
    output logic [CNT_WIDTH-1:0] pass_count,
    output logic [CNT_WIDTH-1:0] drop_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_PASS  = 3'd2;
    localparam logic [2:0] S_DROP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    logic [2:0]           r_state;
    logic [2:0]           r_cnt;
    logic [7:0]           r_hb [0:5];
    logic                 r_tuser;
    logic                 r_overrun;
    logic [7:0]           r_m_tdata;
    logic                 r_m_tvalid;
    logic                 r_m_tlast;
    logic                 r_m_tuser;
    logic [CNT_WIDTH-1:0] r_pass;
    logic [CNT_WIDTH-1:0] r_drop;

    logic                 w_beat;
    logic [47:0]          w_dst;
    logic                 w_mcast;
    logic                 w_match;
    logic                 w_ovr_next;
    logic                 w_inc_pass;
    logic                 w_inc_drop;

    assign w_beat = s_axis_tvalid;
    assign w_dst  = {r_hb[0], r_hb[1], r_hb[2], r_hb[3], r_hb[4], s_axis_tdata};

`ifdef ETH_RX_DST_FILTER_MCAST_EN
    assign w_mcast = w_dst[40];
`else
    assign w_mcast = 1'b0;
`endif

    assign w_match = (w_dst == local_mac) || (w_dst == BCAST_MAC) || promisc || w_mcast;

    // Overrun tracking: set while an offending frame is still open during DRAIN.
    assign w_ovr_next = w_beat ? !s_axis_tlast : r_overrun;

    always_comb begin
        w_inc_pass = 1'b0;
        w_inc_drop = 1'b0;
        case (r_state)
            S_IDLE:  w_inc_drop = w_beat && s_axis_tlast;
            S_HDR:   w_inc_drop = w_beat && ((r_cnt == 3'd5) ? !w_match : s_axis_tlast);
            S_DRAIN: begin
                w_inc_drop = w_beat && !r_overrun;
                w_inc_pass = (r_cnt == 3'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_tuser    <= 1'b0;
            r_overrun  <= 1'b0;
            r_m_tdata  <= 8'd0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                r_hb[i] <= 8'd0;
            end
        end else begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_beat) begin
                        r_hb[0] <= s_axis_tdata;
                        if (!s_axis_tlast) begin
                            r_cnt   <= 3'd1;
                            r_state <= S_HDR;
                        end
                    end
                end
                S_HDR: begin
                    if (w_beat) begin
                        r_hb[r_cnt] <= s_axis_tdata;
                        r_cnt       <= r_cnt + 3'd1;
                        if (r_cnt == 3'd5) begin
                            if (w_match) begin
                                if (s_axis_tlast) begin
                                    r_tuser <= s_axis_tuser;
                                    r_state <= S_DRAIN;
                                end else begin
                                    r_state <= S_PASS;
                                end
                            end else begin
                                r_cnt   <= 3'd0;
                                r_state <= s_axis_tlast ? S_IDLE : S_DROP;
                            end
                        end else if (s_axis_tlast) begin
                            r_cnt   <= 3'd0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_PASS: begin
                    if (w_beat) begin
                        r_m_tdata  <= r_hb[0];
                        r_m_tvalid <= 1'b1;
                        for (int i = 0; i < 5; i++) begin
                            r_hb[i] <= r_hb[i+1];
                        end
                        r_hb[5] <= s_axis_tdata;
                        if (s_axis_tlast) begin
                            r_tuser <= s_axis_tuser;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_m_tdata  <= r_hb[0];
                    r_m_tvalid <= 1'b1;
                    for (int i = 0; i < 5; i++) begin
                        r_hb[i] <= r_hb[i+1];
                    end
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_m_tlast <= 1'b1;
                        r_m_tuser <= r_tuser;
                        r_overrun <= 1'b0;
                        r_state   <= w_ovr_next ? S_DROP : S_IDLE;
                    end else begin
                        r_overrun <= w_ovr_next;
                    end
                end
                S_DROP: begin
                    if (w_beat && s_axis_tlast) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass <= '0;
            r_drop <= '0;
        end else begin
            if (w_inc_pass && !(&r_pass)) begin
                r_pass <= r_pass + 1'b1;
            end
            if (w_inc_drop && !(&r_drop)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tuser  = r_m_tuser;
    assign pass_count    = r_pass;
    assign drop_count    = r_drop;

endmodule

// File: tb/tb_eth_rx_dst_filter.sv
// Self-checking bench for eth_rx_dst_filter: frame table, directed corner sequences, random frames.
module tb_eth_rx_dst_filter;

    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
`ifdef ETH_RX_DST_FILTER_MCAST_EN
    localparam logic MC_EN = 1'b1;
`else
    localparam logic MC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_axis_tdata = 8'd0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic [47:0]   local_mac = LMAC;
    logic          promisc = 1'b0;
    logic [CW-1:0] pass_count;
    logic [CW-1:0] drop_count;

    eth_rx_dst_filter #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .local_mac(local_mac), .promisc(promisc),
        .pass_count(pass_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    typedef struct {
        logic [47:0] dst;
        int          len;
        logic        prom;
        logic        user;
        logic        mii;
        logic        exp_pass;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    int    n_out = 0;
    int    m_pass = 0;
    int    m_drop = 0;
    beat_t exp_q[$];
    vec_t  vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input int x);
        return (x > CMAX) ? 64'(CMAX) : 64'(x);
    endfunction

    // Frame-level acceptance rule.
    function automatic logic ref_match(input logic [47:0] dst, input int len, input logic prom);
        if (len < 6) return 1'b0;
        return (dst == LMAC) || (dst == BCAST) || prom || (MC_EN && dst[40]);
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_axis_tvalid === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h with nothing expected (t=%0t)", m_axis_tdata, $time);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("out_beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, {e.d, e.l, e.u});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [47:0] dst, input int len, input logic prom,
                              input logic user, input logic mii, input logic exp_pass);
        logic [7:0] b;
        logic       last;
        promisc = prom;
        for (int i = 0; i < len; i++) begin
            b = (i < 6) ? dst[47-8*i -: 8] : 8'($urandom);
            last = (i == len - 1);
            s_axis_tdata  = b;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = last;
            s_axis_tuser  = last ? user : 1'($urandom);
            if (exp_pass) exp_q.push_back('{b, last, last & user});
            @(posedge clk);
            #1;
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tuser  = 1'b0;
            if (mii && !last) idle(1);
        end
        if (exp_pass) m_pass++;
        else m_drop++;
    endtask

    initial begin
        logic [7:0]  fb [20];
        logic [47:0] lm;
        logic [63:0] r64;
        logic [47:0] dst;
        int          nb;
        int          len;
        logic        prom;

        vecs[0]  = '{LMAC,               64, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{48'h02_00_00_00_00_02, 64, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{LMAC,               30, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{BCAST,              40, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{48'h12_34_56_78_9A_BC, 50, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{LMAC,                4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{LMAC,                6, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{LMAC,               60, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{48'h01_00_5E_00_00_01, 64, 1'b0, 1'b0, 1'b0, MC_EN};
        vecs[9]  = '{LMAC,                1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{LMAC,                5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{48'h02_00_00_00_00_03,  6, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{48'h12_34_56_78_9A_BC,  5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{BCAST,               7, 1'b0, 1'b1, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_pass", pass_count, 0);
        chk("rst_drop", drop_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        for (int k = 0; k < 14; k++) begin
            nb = n_out;
            send_frame(vecs[k].dst, vecs[k].len, vecs[k].prom, vecs[k].user, vecs[k].mii, vecs[k].exp_pass);
            idle(10);
            chk($sformatf("vec%0d_out_beats", k), 64'(n_out - nb), vecs[k].exp_pass ? 64'(vecs[k].len) : 64'd0);
            chk($sformatf("vec%0d_pass", k), pass_count, sat(m_pass));
            chk($sformatf("vec%0d_drop", k), drop_count, sat(m_drop));
        end

        // PASS latency, then reset in the middle of the frame.
        lm = LMAC;
        promisc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            fb[i] = (i < 6) ? lm[47-8*i -: 8] : 8'($urandom);
            s_axis_tdata  = fb[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = 1'b0;
            if (i < 14) exp_q.push_back('{fb[i], 1'b0, 1'b0});
            @(posedge clk);
            #1;
            s_axis_tvalid = 1'b0;
            if (i == 5) chk("lat_no_early_valid", m_axis_tvalid, 0);
            if (i >= 6) chk("lat_data", {m_axis_tvalid, m_axis_tdata}, {1'b1, fb[i-6]});
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_tlast", m_axis_tlast, 0);
        chk("midrst_pass", pass_count, 0);
        chk("midrst_drop", drop_count, 0);
        chk("midrst_queue", exp_q.size(), 0);
        m_pass = 0;
        m_drop = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Exactly 6-byte frame: six consecutive output cycles, tlast on the sixth.
        send_frame(LMAC, 6, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            idle(1);
            chk("edge6_valid", m_axis_tvalid, 1);
            chk("edge6_last", m_axis_tlast, (k == 6) ? 64'd1 : 64'd0);
        end
        idle(1);
        chk("edge6_after", m_axis_tvalid, 0);
        idle(5);
        chk("edge6_pass", pass_count, sat(m_pass));

        // Frames arriving during DRAIN: a short one ending inside it, a long one outlasting it.
        send_frame(LMAC, 10, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(LMAC, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);
        send_frame(LMAC, 10, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(LMAC, 20, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);
        send_frame(LMAC, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(10);
        chk("ovr_pass", pass_count, sat(m_pass));
        chk("ovr_drop", drop_count, sat(m_drop));

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0: dst = LMAC;
                1: dst = BCAST;
                2: begin
                    r64 = {$urandom(), $urandom()};
                    dst = r64[47:0];
                end
                3: dst = 48'h01_00_5E_00_00_00 | 48'($urandom_range(0, 255));
                default: dst = LMAC ^ (48'd1 << $urandom_range(0, 47));
            endcase
            len  = $urandom_range(1, 70);
            prom = ($urandom_range(0, 3) == 0);
            send_frame(dst, len, prom, 1'($urandom), 1'($urandom), ref_match(dst, len, prom));
            idle($urandom_range(6, 12));
        end
        idle(4);
        chk("rand_pass", pass_count, sat(m_pass));
        chk("rand_drop", drop_count, sat(m_drop));

        for (int k = 0; k < 300; k++) send_frame(LMAC, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("sat_drop", drop_count, sat(m_drop));
        for (int k = 0; k < 260; k++) begin
            send_frame(BCAST, 6, 1'b0, 1'b0, 1'b0, 1'b1);
            idle(6);
        end
        idle(4);
        chk("sat_pass", pass_count, sat(m_pass));
        chk("sat_drop_hold", drop_count, sat(m_drop));

        idle(20);
        chk("exp_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
